ovf_monitor: RTL and testbench

Parametrised multi-channel wrap-around monitor for free-running timer and watchdog counters in the SoC peripheral domain. Each channel samples an external WIDTH-bit counter and detects up-wraps (MAX→0), down-wraps (0→MAX), or any decrease, depending on its mode. Per channel it produces:
- a one-cycle event pulse;
- a sticky flag;
- a saturating event count.

A single maskable level interrupt combines all channels for the event unit.

---
 rtl/ovf_monitor_pkg.sv | 16 +
 rtl/ovf_monitor_ch.sv | 66 ++++++
 rtl/ovf_monitor.sv | 41 ++++
 tb/tb_ovf_monitor.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ovf_monitor_pkg.sv
// ovf_monitor_pkg: wrap-detection mode encoding shared by the monitor and its channels
package ovf_monitor_pkg;

    localparam logic [1:0] OVF_MODE_OFF  = 2'b00;
    localparam logic [1:0] OVF_MODE_UP   = 2'b01;
    localparam logic [1:0] OVF_MODE_DOWN = 2'b10;
    localparam logic [1:0] OVF_MODE_DEC  = 2'b11;

    typedef enum logic [1:0] {
        OVF_OFF  = OVF_MODE_OFF,
        OVF_UP   = OVF_MODE_UP,
        OVF_DOWN = OVF_MODE_DOWN,
        OVF_DEC  = OVF_MODE_DEC
    } ovf_mode_e;

endpackage

// File: rtl/ovf_monitor_ch.sv
// ovf_monitor_ch: single-channel wrap detector with event pulse, sticky flag and saturating count
module ovf_monitor_ch
    import ovf_monitor_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int EVT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] i_cnt,
    input  logic             i_valid,
    input  logic [1:0]       i_mode,
    input  logic             i_clr,
    output logic             o_pulse,
    output logic             o_sticky,
    output logic [EVT_W-1:0] o_evt
);

    ovf_mode_e        w_mode;
    logic             w_hit;
    logic             w_det;
    logic [EVT_W-1:0] w_evt_nxt;
    logic [WIDTH-1:0] r_prev;
    logic             r_prev_vld;
    logic             r_pulse;
    logic             r_sticky;
    logic [EVT_W-1:0] r_evt;

    assign w_mode = ovf_mode_e'(i_mode);

    always_comb begin
        w_hit = (w_mode == OVF_UP)   ? (&r_prev && ~|i_cnt) :
                (w_mode == OVF_DOWN) ? (~|r_prev && &i_cnt) :
                (w_mode == OVF_DEC)  ? (i_cnt < r_prev)     : 1'b0;
    end

    // A detect in the same cycle as a clear restarts the count at one.
    assign w_det     = i_valid && r_prev_vld && w_hit;
    assign w_evt_nxt = w_det ? (i_clr ? EVT_W'(1) : (&r_evt ? r_evt : r_evt + 1'b1)) :
                       i_clr ? '0 : r_evt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
            r_pulse    <= 1'b0;
            r_sticky   <= 1'b0;
            r_evt      <= '0;
        end else begin
            r_pulse  <= w_det;
            r_sticky <= w_det | (r_sticky & ~i_clr);
            r_evt    <= w_evt_nxt;
            if (w_mode == OVF_OFF) begin
                r_prev_vld <= 1'b0;
            end else if (i_valid) begin
                r_prev     <= i_cnt;
                r_prev_vld <= 1'b1;
            end
        end
    end

    assign o_pulse  = r_pulse;
    assign o_sticky = r_sticky;
    assign o_evt    = r_evt;

endmodule

// File: rtl/ovf_monitor.sv
// ovf_monitor: multi-channel counter wrap monitor with a combined maskable interrupt
module ovf_monitor
    import ovf_monitor_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int WIDTH = 32,
    parameter int EVT_W = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NCH-1:0][WIDTH-1:0]  cnt_i,
    input  logic [NCH-1:0]             valid_i,
    input  logic [NCH-1:0][1:0]        mode_i,
    input  logic [NCH-1:0]             irq_en_i,
    input  logic [NCH-1:0]             clr_i,
    output logic [NCH-1:0]             ovf_pulse_o,
    output logic [NCH-1:0]             ovf_sticky_o,
    output logic [NCH-1:0][EVT_W-1:0]  evt_cnt_o,
    output logic                       irq_o
);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        ovf_monitor_ch #(
            .WIDTH(WIDTH),
            .EVT_W(EVT_W)
        ) u_ch (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .i_cnt   (cnt_i[c]),
            .i_valid (valid_i[c]),
            .i_mode  (mode_i[c]),
            .i_clr   (clr_i[c]),
            .o_pulse (ovf_pulse_o[c]),
            .o_sticky(ovf_sticky_o[c]),
            .o_evt   (evt_cnt_o[c])
        );
    end

    assign irq_o = |(ovf_sticky_o & irq_en_i);

endmodule

// File: tb/tb_ovf_monitor.sv
// tb_ovf_monitor: vector table, directed corner sequences and a randomized model comparison
module tb_ovf_monitor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0][31:0] cnt;
    logic [3:0]       valid, en, clr, pulse, sticky;
    logic [3:0][1:0]  mode;
    logic [3:0][7:0]  evt;
    logic             irq;

    logic [1:0][2:0]  s_cnt;
    logic [1:0]       s_valid, s_en, s_clr, s_pulse, s_sticky;
    logic [1:0][1:0]  s_mode;
    logic [1:0][1:0]  s_evt;
    logic             s_irq;

    ovf_monitor u_dut (
        .clk_i(clk), .rst_ni(rst_n), .cnt_i(cnt), .valid_i(valid), .mode_i(mode),
        .irq_en_i(en), .clr_i(clr), .ovf_pulse_o(pulse), .ovf_sticky_o(sticky),
        .evt_cnt_o(evt), .irq_o(irq)
    );

    ovf_monitor #(.NCH(2), .WIDTH(3), .EVT_W(2)) u_sat (
        .clk_i(clk), .rst_ni(rst_n), .cnt_i(s_cnt), .valid_i(s_valid), .mode_i(s_mode),
        .irq_en_i(s_en), .clr_i(s_clr), .ovf_pulse_o(s_pulse), .ovf_sticky_o(s_sticky),
        .evt_cnt_o(s_evt), .irq_o(s_irq)
    );

    int pass = 0;
    int total = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        bit v; int md; longint c; bit cl; bit e;
        bit p; bit s; int n; bit q;
    } vec_t;

    function automatic vec_t row(bit v, int md, longint c, bit cl, bit e, bit p, bit s, int n, bit q);
        vec_t r;
        r.v = v; r.md = md; r.c = c; r.cl = cl; r.e = e;
        r.p = p; r.s = s; r.n = n; r.q = q;
        return r;
    endfunction

    // Reference model: six channels, 0-3 on the wide instance, 4-5 on the narrow one.
    longint m_prev[6];
    bit     m_vld[6], m_pulse[6], m_sticky[6];
    int     m_evt[6];

    function automatic void mreset();
        for (int k = 0; k < 6; k++) begin
            m_prev[k] = 0; m_vld[k] = 0; m_pulse[k] = 0; m_sticky[k] = 0; m_evt[k] = 0;
        end
    endfunction

    function automatic void mstep(int k, bit v, int md, longint cur, longint maxv, int emax, bit c);
        bit hit;
        hit = v && m_vld[k] &&
              ((md == 1 && m_prev[k] == maxv && cur == 0) ||
               (md == 2 && m_prev[k] == 0 && cur == maxv) ||
               (md == 3 && cur < m_prev[k]));
        m_pulse[k] = hit;
        if (c) begin
            m_sticky[k] = 0;
            m_evt[k] = 0;
        end
        if (hit) begin
            m_sticky[k] = 1;
            m_evt[k] = (m_evt[k] + 1 > emax) ? emax : m_evt[k] + 1;
        end
        if (md == 0) m_vld[k] = 0;
        else if (v) begin
            m_prev[k] = cur;
            m_vld[k] = 1;
        end
    endfunction

    task automatic idle_in();
        cnt = '0; valid = '0; en = '0; clr = '0; mode = '0;
        s_cnt = '0; s_valid = '0; s_en = '0; s_clr = '0; s_mode = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_in();
        mreset();
        repeat (2) @(negedge clk);
        chk("rst_pulse", pulse, 0);
        chk("rst_sticky", sticky, 0);
        chk("rst_evt", evt, 0);
        chk("rst_irq", irq, 0);
        chk("rst_sat_state", {s_pulse, s_sticky, s_evt, s_irq}, 0);
        rst_n = 1'b1;
    endtask

    vec_t tbl[22];
    logic [3:0] exp_p, exp_s, exp_e;
    logic [1:0] sexp_p, sexp_s, sexp_e;
    bit exp_q, sexp_q;

    initial begin
        tbl[0]  = row(1, 1, 64'hFFFFFFFE, 0, 1, 0, 0, 0, 0);
        tbl[1]  = row(1, 1, 64'hFFFFFFFF, 0, 1, 0, 0, 0, 0);
        tbl[2]  = row(1, 1, 0,            0, 1, 1, 1, 1, 1);
        tbl[3]  = row(0, 1, 0,            0, 1, 0, 1, 1, 1);
        tbl[4]  = row(0, 1, 0,            0, 0, 0, 1, 1, 0);
        tbl[5]  = row(1, 2, 0,            0, 1, 0, 1, 1, 1);
        tbl[6]  = row(1, 2, 64'hFFFFFFFF, 0, 1, 1, 1, 2, 1);
        tbl[7]  = row(1, 3, 100,          1, 1, 1, 1, 1, 1);
        tbl[8]  = row(0, 3, 0,            1, 1, 0, 0, 0, 0);
        for (int i = 9; i < 14; i++) tbl[i] = row(0, 3, 7, 0, 1, 0, 0, 0, 0);
        tbl[14] = row(1, 3, 7,            0, 1, 1, 1, 1, 1);
        tbl[15] = row(1, 3, 3,            0, 1, 1, 1, 2, 1);
        tbl[16] = row(1, 0, 64'hFFFFFFFF, 0, 1, 0, 1, 2, 1);
        tbl[17] = row(1, 1, 64'hFFFFFFFF, 0, 1, 0, 1, 2, 1);
        tbl[18] = row(1, 1, 0,            0, 1, 1, 1, 3, 1);
        tbl[19] = row(1, 3, 5,            1, 1, 0, 0, 0, 0);
        tbl[20] = row(1, 3, 5,            0, 1, 0, 0, 0, 0);
        tbl[21] = row(1, 3, 4,            0, 1, 1, 1, 1, 1);

        @(negedge clk);
        do_reset();
        for (int i = 0; i < 22; i++) begin
            valid[0] = tbl[i].v; mode[0] = 2'(tbl[i].md); cnt[0] = 32'(tbl[i].c);
            clr[0] = tbl[i].cl; en[0] = tbl[i].e;
            @(negedge clk);
            chk("tbl_pulse", pulse, {3'b0, tbl[i].p});
            chk("tbl_sticky", sticky, {3'b0, tbl[i].s});
            chk("tbl_evt", evt[0], tbl[i].n);
            chk("tbl_irq", irq, tbl[i].q);
        end

        // First sample after reset only primes, in UP and in DOWN.
        do_reset();
        mode[0] = 2'd1; valid[0] = 1; cnt[0] = 0;
        @(negedge clk);
        chk("prime_up_pulse", pulse[0], 0);
        do_reset();
        mode[0] = 2'd2; valid[0] = 1; cnt[0] = 32'hFFFFFFFF;
        @(negedge clk);
        chk("prime_down_pulse", pulse[0], 0);
        cnt[0] = 0;
        @(negedge clk);
        chk("down_nowrap_pulse", pulse[0], 0);
        cnt[0] = 32'hFFFFFFFF;
        @(negedge clk);
        chk("down_wrap_pulse", pulse[0], 1);
        chk("down_wrap_evt", evt[0], 1);

        // Simultaneous wraps on channels 0 and 3 only.
        do_reset();
        mode = {4{2'd1}}; valid = 4'b1111; cnt = {4{32'hFFFFFFFF}};
        @(negedge clk);
        chk("multi_prime_pulse", pulse, 0);
        cnt = {32'h0, 32'h5, 32'h5, 32'h0};
        @(negedge clk);
        chk("multi_pulse", pulse, 4'b1001);
        chk("multi_sticky", sticky, 4'b1001);
        valid = 0; en = 4'b0001;
        #1 chk("irq_en0", irq, 1);
        en = 4'b0110;
        #1 chk("irq_en_masked", irq, 0);
        en = 4'b0001; clr = 4'b0001;
        @(negedge clk);
        chk("clr0_sticky", sticky, 4'b1000);
        chk("clr0_irq", irq, 0);
        chk("clr0_evt3", evt[3], 1);
        clr = 0;

        // Reset in the middle of a wrap sequence.
        do_reset();
        mode[0] = 2'd1; valid[0] = 1; en[0] = 1; cnt[0] = 32'hFFFFFFFF;
        @(negedge clk);
        cnt[0] = 0;
        @(negedge clk);
        chk("pre_rst_sticky", sticky[0], 1);
        cnt[0] = 32'hFFFFFFFF;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_state", {pulse, sticky, evt[0], irq}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt[0] = 0;
        @(negedge clk);
        chk("post_rst_state", {pulse, sticky, evt[0], irq}, 0);

        // Saturation on the 2-bit counter, then clear interplay.
        do_reset();
        s_mode[0] = 2'd1; s_valid[0] = 1; s_en[0] = 1;
        for (int i = 0; i < 5; i++) begin
            s_cnt[0] = 3'd7;
            @(negedge clk);
            s_cnt[0] = 3'd0;
            @(negedge clk);
        end
        chk("sat_evt", s_evt[0], 3);
        chk("sat_sticky", s_sticky[0], 1);
        s_cnt[0] = 3'd7;
        @(negedge clk);
        s_cnt[0] = 3'd0; s_clr[0] = 1;
        @(negedge clk);
        chk("clr_wrap_sticky", s_sticky[0], 1);
        chk("clr_wrap_evt", s_evt[0], 1);
        s_valid[0] = 0;
        @(negedge clk);
        chk("clr_only_sticky", s_sticky[0], 0);
        chk("clr_only_evt", s_evt[0], 0);
        chk("clr_only_irq", s_irq, 0);

        // Randomized run against the model.
        do_reset();
        for (int t = 0; t < 2000; t++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 9) == 0) mode[k] = 2'($urandom_range(0, 3));
                valid[k] = $urandom_range(0, 9) < 7;
                clr[k] = $urandom_range(0, 11) == 0;
                en[k] = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 4))
                    0: cnt[k] = 0;
                    1: cnt[k] = 32'hFFFFFFFF;
                    2: cnt[k] = cnt[k] - 1;
                    3: cnt[k] = cnt[k] + 1;
                    default: cnt[k] = $urandom;
                endcase
                mstep(k, valid[k], mode[k], cnt[k], 64'hFFFFFFFF, 255, clr[k]);
            end
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 9) == 0) s_mode[k] = 2'($urandom_range(0, 3));
                s_valid[k] = $urandom_range(0, 9) < 7;
                s_clr[k] = $urandom_range(0, 15) == 0;
                s_en[k] = 1'($urandom_range(0, 1));
                s_cnt[k] = 3'($urandom_range(0, 7));
                mstep(k + 4, s_valid[k], s_mode[k], s_cnt[k], 7, 3, s_clr[k]);
            end
            @(negedge clk);
            exp_q = 0;
            for (int k = 0; k < 4; k++) begin
                chk("rnd_pulse", pulse[k], m_pulse[k]);
                chk("rnd_sticky", sticky[k], m_sticky[k]);
                chk("rnd_evt", evt[k], m_evt[k]);
                exp_q |= m_sticky[k] & en[k];
            end
            chk("rnd_irq", irq, exp_q);
            sexp_q = 0;
            for (int k = 0; k < 2; k++) begin
                chk("rnd_s_pulse", s_pulse[k], m_pulse[k + 4]);
                chk("rnd_s_sticky", s_sticky[k], m_sticky[k + 4]);
                chk("rnd_s_evt", s_evt[k], m_evt[k + 4]);
                sexp_q |= m_sticky[k + 4] & s_en[k];
            end
            chk("rnd_s_irq", s_irq, sexp_q);
        end

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
